delay_cal_ctrl: RTL and testbench

- Calibration controller that sits directly upstream of the 4-bit programmable clock delay line.
- Sweeps the delay code `delay_o` from 0 upward and samples the fed-back delayed clock (`ref_sample`) through a synchronizer.
- Locks on the first code where the majority-sampled level rises from 0 to 1, then holds that code on `delay_o` for the delay line.

---
 rtl/delay_cal_pkg.sv | 23 ++
 rtl/delay_cal_sync.sv | 28 ++
 rtl/delay_cal_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_delay_cal_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_cal_pkg.sv
// Shared types for the delay-line calibration controller.
//   DEF_CODE_W   : default delay code width
//   delay_code_t : delay code at the default width
//   cal_state_e  : calibration FSM states
//   max_u        : elaboration-time helper for sizing counters
package delay_cal_pkg;

  localparam int unsigned DEF_CODE_W = 4;

  typedef logic [DEF_CODE_W-1:0] delay_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DECIDE = 2'd3
  } cal_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/delay_cal_sync.sv
// Multi-flop synchronizer for the asynchronous fed-back delayed clock.
// Ports:
//   clk, rst_n : clock and async active-low reset (flops reset to 0)
//   d_i        : asynchronous input
//   q_o        : synchronized output (last flop of the chain)
module delay_cal_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; bit 0 is the metastability-catching flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/delay_cal_ctrl.sv
// Calibration controller for a programmable clock delay line. Sweeps the
// delay code upward from 0, majority-samples the synchronized fed-back clock
// at each code and locks on the first 0->1 level transition.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : one-cycle calibration request (honoured in IDLE only)
//   ref_sample  : asynchronous delayed clock from the delay line
//   delay_o     : delay code to the delay line
//   busy        : calibration in progress
//   done        : one-cycle end-of-calibration pulse
//   locked      : sticky success flag, lock_code valid while set
//   lock_code   : code found by the sweep
//   err         : sticky failure flag (no rising transition found)
// Optional build macro DELAY_CAL_OVERRIDE_EN adds ovr_en/ovr_code, which
// force the delay code while idle.
module delay_cal_ctrl
  import delay_cal_pkg::*;
#(
  parameter int unsigned CODE_W        = DEF_CODE_W,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ref_sample,
`ifdef DELAY_CAL_OVERRIDE_EN
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
`endif
  output logic [CODE_W-1:0] delay_o,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [CODE_W-1:0] lock_code,
  output logic              err
);

  localparam int unsigned CNT_W  = $clog2(max_u(SETTLE_CYCLES, SAMPLES));
  localparam int unsigned ONES_W = $clog2(SAMPLES) + 1;
  localparam logic [CODE_W-1:0] MAX_CODE = '1;

  cal_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [CODE_W-1:0] delay_q, delay_d;
  logic [CODE_W-1:0] lock_code_q, lock_code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              prev_q, prev_d;
  logic              first_q, first_d;
  logic              sync_level;
  logic              cur_level_c;
  logic              ovr_active_c;
  logic [CODE_W-1:0] ovr_code_c;

  delay_cal_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ref_sample),
    .q_o   (sync_level)
  );

`ifdef DELAY_CAL_OVERRIDE_EN
  assign ovr_active_c = ovr_en;
  assign ovr_code_c   = ovr_code;
`else
  assign ovr_active_c = 1'b0;
  assign ovr_code_c   = '0;
`endif

  // Majority vote: a tie counts as high.
  assign cur_level_c = (ones_q >= ONES_W'(SAMPLES / 2));

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    delay_d     = delay_q;
    lock_code_d = lock_code_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    locked_d    = locked_q;
    err_d       = err_q;
    prev_d      = prev_q;
    first_d     = first_q;

    case (state_q)
      ST_IDLE: begin
        delay_d = locked_q ? lock_code_q : '0;
        if (ovr_active_c) begin
          delay_d = ovr_code_c;
        end else if (start) begin
          busy_d   = 1'b1;
          locked_d = 1'b0;
          err_d    = 1'b0;
          delay_d  = '0;
          first_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_APPLY;
        end
      end

      ST_APPLY: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        ones_d = ones_q + ONES_W'(sync_level);
        if (cnt_q == CNT_W'(SAMPLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DECIDE: begin
        if (!first_q && !prev_q && cur_level_c) begin
          lock_code_d = delay_q;
          locked_d    = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (delay_q == MAX_CODE) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          delay_d = '0;
          state_d = ST_IDLE;
        end else begin
          prev_d  = cur_level_c;
          first_d = 1'b0;
          delay_d = delay_q + CODE_W'(1);
          cnt_d   = '0;
          state_d = ST_APPLY;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ones_q      <= '0;
      delay_q     <= '0;
      lock_code_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      prev_q      <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      delay_q     <= delay_d;
      lock_code_q <= lock_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
    end
  end

  assign delay_o   = delay_q;
  assign lock_code = lock_code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Self-checking bench for delay_cal_ctrl. The delay line is modelled as a
// per-code level table (optionally one code toggling at 50% duty); the
// expected lock code, flags and done latency come from a sweep model.
// Define DELAY_CAL_OVERRIDE_EN to also exercise the override ports.
module tb_delay_cal_ctrl;

  localparam int NCODES   = 16;
  localparam int PER_CODE = 4 + 16 + 1;
  localparam int BUDGET   = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ref_sample;
  logic [3:0] delay_o;
  logic       busy;
  logic       done;
  logic       locked;
  logic [3:0] lock_code;
  logic       err;
`ifdef DELAY_CAL_OVERRIDE_EN
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_code = 4'd0;
`endif

  logic [15:0] level_map = 16'h0000;
  logic        tog_en = 1'b0;
  logic [3:0]  tog_code = 4'd0;
  logic        tog_q = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int exp_idle_delay = 0;

  delay_cal_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ref_sample (ref_sample),
`ifdef DELAY_CAL_OVERRIDE_EN
    .ovr_en     (ovr_en),
    .ovr_code   (ovr_code),
`endif
    .delay_o    (delay_o),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .lock_code  (lock_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Delay line model: a fixed level per code, or a clock-rate toggle on one code.
  always @(posedge clk) tog_q <= ~tog_q;
  assign ref_sample = (tog_en && delay_o == tog_code) ? tog_q : level_map[delay_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sweep model: the first code c>0 whose level is 1 after a 0 at c-1 locks.
  function automatic void model(input logic [15:0] map, input logic ten, input int tcode,
                                output logic lk, output int code, output int cyc);
    logic lvl [NCODES];
    for (int c = 0; c < NCODES; c++) lvl[c] = (ten && c == tcode) ? 1'b1 : map[c];
    lk   = 1'b0;
    code = 0;
    cyc  = 1 + PER_CODE * NCODES;
    for (int c = 1; c < NCODES; c++) begin
      if (!lk && !lvl[c-1] && lvl[c]) begin
        lk   = 1'b1;
        code = c;
        cyc  = 1 + PER_CODE * (c + 1);
      end
    end
  endfunction

  // Caller must be at a negedge; start is raised in the current cycle.
  task automatic run_sweep(input string tag, input int mid_n);
    logic exp_lk;
    int   exp_code;
    int   exp_cyc;
    int   n;
    logic busy_drop;
    model(level_map, tog_en, int'(tog_code), exp_lk, exp_code, exp_cyc);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    n         = 1;
    busy_drop = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    chk({tag, "_err_clr"}, 32'(err), 32'd0);
    chk({tag, "_lk_clr"}, 32'(locked), 32'd0);
    while (!done && n < BUDGET) begin
      if (!busy) busy_drop = 1'b1;
      @(negedge clk);
      n++;
      start = (n == mid_n);
    end
    start = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_busy_hold"}, 32'(busy_drop), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'(exp_lk));
    chk({tag, "_err"}, 32'(err), 32'(!exp_lk));
    if (exp_lk) chk({tag, "_lock_code"}, 32'(lock_code), 32'(exp_code));
    chk({tag, "_delay"}, 32'(delay_o), 32'(exp_lk ? exp_code : 0));
    exp_idle_delay = exp_lk ? exp_code : 0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_delay_hold"}, 32'(delay_o), 32'(exp_idle_delay));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_delay", 32'(delay_o), 32'd0);
    chk("rst_lock_code", 32'(lock_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    level_map = 16'hFFC0;               // level 1 from code 6
    run_sweep("ge6", 0);
    level_map = 16'hFFFF;               // already high at code 0
    run_sweep("all1", 0);
    level_map = 16'h0000;               // never high
    run_sweep("all0", 0);
    level_map = 16'hFFF8;               // back-to-back restart after an error
    run_sweep("ge3", 0);
    level_map = 16'hFE1C;               // 1 at 2..4, 0 at 5..8; extra start mid-sweep
    run_sweep("dip", 30);

    // Async reset while sampling code 4; lock_code is nonzero beforehand.
    level_map = 16'hFFC0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (delay_o != 4'd4 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach", 32'(n < BUDGET), 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_delay", 32'(delay_o), 32'd0);
    chk("rst_mid_lock_code", 32'(lock_code), 32'd0);
    chk("rst_mid_locked", 32'(locked), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep("post_rst", 0);

    // 50% duty at code 1 counts as high.
    level_map = 16'h0000;
    tog_en    = 1'b1;
    tog_code  = 4'd1;
    run_sweep("tog", 0);
    tog_en = 1'b0;

    for (int i = 0; i < 5; i++) begin
      level_map = 16'($urandom);
      tog_en    = 1'($urandom_range(0, 1));
      tog_code  = 4'($urandom_range(0, 15));
      run_sweep($sformatf("rnd%0d", i), int'($urandom_range(2, 60)));
    end
    tog_en = 1'b0;

`ifdef DELAY_CAL_OVERRIDE_EN
    ovr_code = 4'd9;
    ovr_en   = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    chk("ovr_delay", 32'(delay_o), 32'd9);
    chk("ovr_start_ignored", 32'(busy), 32'd0);
    start  = 1'b0;
    ovr_en = 1'b0;
    @(negedge clk);
    chk("ovr_release", 32'(delay_o), 32'(exp_idle_delay));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
